// File: rtl/reg_write_sched_pkg.sv
// Constants shared by the register file, decode and the write-port scheduler.
package reg_write_sched_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ZERO   = 0;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/reg_write_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after ptr.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    int unsigned      pos;
    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = pos[PTR_W-1:0];
            if (!found && valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/reg_write_sched.sv
// Shares the register-file write port between write-back sources and keeps
// the busy scoreboard that decode uses to stall on RAW/WAW hazards.
module reg_write_sched
    import reg_write_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ*ADDR_W-1:0] reqReg,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    output logic [NUM_REQ-1:0]        reqReady,
    input  logic                      reserveEn,
    input  logic [ADDR_W-1:0]         reserveReg,
    output logic                      reserveOk,
    input  logic [ADDR_W-1:0]         regA,
    input  logic [ADDR_W-1:0]         regB,
    output logic                      busyA,
    output logic                      busyB,
    output logic                      writeEnable,
    output logic [ADDR_W-1:0]         regWrite,
    output logic [DATA_W-1:0]         writeData,
    output logic                      errFlag
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   regw_q, regw_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_any;
    logic [ADDR_W-1:0]   sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic                set_en;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .valid_i (reqValid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    assign reqReady = grant;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_reg  = reqReg[i*ADDR_W +: ADDR_W];
                sel_data = reqData[i*DATA_W +: DATA_W];
            end
        end
    end

    // reserveOk looks at the registered busy vector, so a clear landing on
    // this same edge cannot open the register early.
    assign reserveOk = (reserveReg == ADDR_W'(REG_ZERO)) || !busy_q[reserveReg];
    assign set_en    = reserveEn && reserveOk && (reserveReg != ADDR_W'(REG_ZERO));
    assign busyA     = busy_q[regA];
    assign busyB     = busy_q[regB];

    always_comb begin
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        regw_d  = regw_q;
        wdata_d = wdata_q;
        if (grant_any) begin
            ptr_d   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            we_d    = (sel_reg != ADDR_W'(REG_ZERO));
            regw_d  = sel_reg;
            wdata_d = sel_data;
        end
        err_d  = err_q | (reserveEn & ~reserveOk);
        // Clear first so a same-edge reservation of the same register wins.
        busy_d = busy_q;
        if (we_q) begin
            busy_d[regw_q] = 1'b0;
        end
        if (set_en) begin
            busy_d[reserveReg] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ptr_q   <= '0;
            busy_q  <= '0;
            we_q    <= 1'b0;
            regw_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            regw_q  <= regw_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign writeEnable = we_q;
    assign regWrite    = regw_q;
    assign writeData   = wdata_q;
    assign errFlag     = err_q;

endmodule

// File: tb/tb_reg_write_sched.sv
// Bench for reg_write_sched: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the scheduler.
module tb_reg_write_sched;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            resetN;
    logic [N-1:0]    reqValid;
    logic [N*AW-1:0] reqReg;
    logic [N*DW-1:0] reqData;
    logic [N-1:0]    reqReady;
    logic            reserveEn;
    logic [AW-1:0]   reserveReg;
    logic            reserveOk;
    logic [AW-1:0]   regA, regB;
    logic            busyA, busyB;
    logic            writeEnable;
    logic [AW-1:0]   regWrite;
    logic [DW-1:0]   writeData;
    logic            errFlag;

    int total = 0;
    int bad   = 0;

    reg_write_sched #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .clock       (clock),
        .resetN      (resetN),
        .reqValid    (reqValid),
        .reqReg      (reqReg),
        .reqData     (reqData),
        .reqReady    (reqReady),
        .reserveEn   (reserveEn),
        .reserveReg  (reserveReg),
        .reserveOk   (reserveOk),
        .regA        (regA),
        .regB        (regB),
        .busyA       (busyA),
        .busyB       (busyB),
        .writeEnable (writeEnable),
        .regWrite    (regWrite),
        .writeData   (writeData),
        .errFlag     (errFlag)
    );

    always #5 clock = ~clock;

    // Behavioural model: pending-write slot, pointer and a per-register busy array.
    int          m_ptr  = 0;
    bit          m_busy [32];
    bit          m_we   = 0;
    int          m_reg  = 0;
    logic [31:0] m_data = '0;
    bit          m_err  = 0;

    function automatic int pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m_ptr = 0; m_we = 0; m_reg = 0; m_data = '0; m_err = 0;
            for (int r = 0; r < 32; r++) m_busy[r] = 0;
        end else begin
            int g;
            bit ok;
            bit old_we;
            int old_reg;
            old_we  = m_we;
            old_reg = m_reg;
            ok      = (reserveReg == 0) || !m_busy[reserveReg];
            g       = pick(reqValid, m_ptr);
            if (g >= 0) begin
                m_reg  = int'(reqReg[g*AW +: AW]);
                m_data = reqData[g*DW +: DW];
                m_we   = (m_reg != 0);
                m_ptr  = (g + 1) % N;
            end else begin
                m_we = 0;
            end
            if (old_we) m_busy[old_reg] = 0;
            if (reserveEn) begin
                if (!ok) m_err = 1;
                else if (reserveReg != 0) m_busy[reserveReg] = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        int g;
        logic [N-1:0] er;
        g  = pick(reqValid, m_ptr);
        er = (g >= 0) ? N'(1 << g) : '0;
        chk("m_ready", 64'(reqReady), 64'(er));
        chk("m_we",    64'(writeEnable), 64'(m_we));
        chk("m_reg",   64'(regWrite), 64'(m_reg));
        chk("m_data",  64'(writeData), 64'(m_data));
        chk("m_err",   64'(errFlag), 64'(m_err));
        chk("m_busyA", 64'(busyA), 64'(m_busy[regA]));
        chk("m_busyB", 64'(busyB), 64'(m_busy[regB]));
        chk("m_resok", 64'(reserveOk), 64'((reserveReg == 0) || !m_busy[reserveReg]));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        reqValid[i]         = v;
        reqReg[i*AW +: AW]  = r;
        reqData[i*DW +: DW] = d;
    endtask

    initial begin
        logic [N-1:0] hs;
        resetN = 1'b0; reqValid = '0; reqReg = '0; reqData = '0;
        reserveEn = 1'b0; reserveReg = '0; regA = '0; regB = '0;
        repeat (2) step();
        resetN = 1'b1;
        step();

        // Single write from requester 1.
        set_req(1, 1, 5'd7, 32'hDEADBEEF);
        #1 chk("single_ready", 64'(reqReady), 64'b010);
        step();
        reqValid = '0;
        #1;
        chk("single_we",   64'(writeEnable), 64'd1);
        chk("single_reg",  64'(regWrite), 64'd7);
        chk("single_data", 64'(writeData), 64'hDEADBEEF);

        // Reserve r5, then reset mid-stream.
        regA = 5'd5; reserveEn = 1'b1; reserveReg = 5'd5;
        step();
        reserveEn = 1'b0;
        #1 chk("pre_reset_busy", 64'(busyA), 64'd1);
        set_req(0, 1, 5'd1, 32'h11); set_req(1, 1, 5'd2, 32'h22); set_req(2, 1, 5'd3, 32'h33);
        resetN = 1'b0;
        #1;
        chk("rst_we",    64'(writeEnable), 64'd0);
        chk("rst_reg",   64'(regWrite), 64'd0);
        chk("rst_data",  64'(writeData), 64'd0);
        chk("rst_err",   64'(errFlag), 64'd0);
        chk("rst_busy",  64'(busyA), 64'd0);
        chk("rst_ready", 64'(reqReady), 64'b001);
        step();
        resetN = 1'b1;

        // Round-robin with all three held valid.
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_grant", 64'(reqReady), 64'(1 << (k % 3)));
            step();
            chk("rr_we", 64'(writeEnable), 64'd1);
        end
        reqValid = '0;

        // Scoreboard timing on r5.
        regA = 5'd5; reserveEn = 1'b1; reserveReg = 5'd5;
        step();
        reserveEn = 1'b0;
        #1;
        chk("sb_busy_set", 64'(busyA), 64'd1);
        chk("sb_resok",    64'(reserveOk), 64'd0);
        set_req(0, 1, 5'd5, 32'h55);
        #1 chk("sb_ready", 64'(reqReady), 64'b001);
        step();
        reqValid = '0;
        #1;
        chk("sb_busy_n1", 64'(busyA), 64'd1);
        step();
        chk("sb_busy_n2", 64'(busyA), 64'd0);

        // WAW: double reservation of r9.
        regB = 5'd9; reserveEn = 1'b1; reserveReg = 5'd9;
        step();
        step();
        reserveEn = 1'b0;
        #1;
        chk("waw_err",  64'(errFlag), 64'd1);
        chk("waw_busy", 64'(busyB), 64'd1);
        set_req(2, 1, 5'd9, 32'h99);
        #1 chk("waw_ready", 64'(reqReady), 64'b100);
        step();
        reqValid = '0;
        chk("waw_busy_n1", 64'(busyB), 64'd1);
        step();
        chk("waw_busy_n2", 64'(busyB), 64'd0);

        // r0 write and reservation.
        set_req(1, 1, 5'd0, 32'hAA);
        #1 chk("r0_ready", 64'(reqReady), 64'b010);
        step();
        reqValid = '0;
        chk("r0_we", 64'(writeEnable), 64'd0);
        regA = 5'd0; reserveEn = 1'b1; reserveReg = 5'd0;
        #1 chk("r0_resok", 64'(reserveOk), 64'd1);
        step();
        reserveEn = 1'b0;
        chk("r0_busy", 64'(busyA), 64'd0);

        // Reserve of r3 on the edge that clears r3: the set wins.
        regA = 5'd3;
        set_req(0, 1, 5'd3, 32'h33);
        step();
        reqValid = '0;
        reserveEn = 1'b1; reserveReg = 5'd3;
        #1;
        chk("col_we",    64'(writeEnable), 64'd1);
        chk("col_resok", 64'(reserveOk), 64'd1);
        step();
        reserveEn = 1'b0;
        chk("col_busy", 64'(busyA), 64'd1);

        // Randomized traffic honouring the hold-until-handshake rule.
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            hs = reqValid & reqReady;
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] || !reqValid[i]) begin
                    set_req(i, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
                end
            end
            reserveEn  = ($urandom_range(0, 9) < 3);
            reserveReg = 5'($urandom_range(0, 7));
            regA       = 5'($urandom_range(0, 7));
            regB       = 5'($urandom_range(0, 31));
        end
        reqValid = '0; reserveEn = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
